// File: rtl/sobel_stream_pkg.sv
// sobel_stream_pkg: shared definitions for the Sobel stream controller.
//   - CI op codes carried in valueB[1:0]
//   - sequencing FSM state type
//   - image width limits and the magnitude saturation value
package sobel_stream_pkg;

    localparam logic [1:0] OP_CONFIG = 2'd0;
    localparam logic [1:0] OP_PUSH   = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        C0,
        C1,
        C2,
        C3,
        DONE
    } state_t;

    localparam logic [10:0] WIDTH_MIN = 11'd8;
    localparam logic [7:0]  SAT_MAX   = 8'd255;

    // A width is usable when it is a whole number of 4-pixel words and in range.
    function automatic logic width_ok(input logic [10:0] w, input logic [10:0] wmax);
        return (w[1:0] == 2'b00) && (w >= WIDTH_MIN) && (w <= wmax);
    endfunction

endpackage

// File: rtl/sobel_stream_ctrl_kernel.sv
// sobel_kernel: combinational 3x3 Sobel magnitude.
// Ports:
//   i_nbr : 8 neighbour pixels, p0 in [7:0] .. p7 in [63:56], row-major with
//           the centre pixel excluded
//   o_mag : |Gx| + |Gy| saturated to 255
module sobel_kernel
    import sobel_stream_pkg::*;
(
    input  logic [63:0] i_nbr,
    output logic [7:0]  o_mag
);

    logic [7:0]  w_p0, w_p1, w_p2, w_p3, w_p4, w_p5, w_p6, w_p7;
    logic [11:0] w_xp, w_xn, w_yp, w_yn;
    logic [11:0] w_ax, w_ay, w_sum;

    assign {w_p7, w_p6, w_p5, w_p4, w_p3, w_p2, w_p1, w_p0} = i_nbr;

    // Positive and negative halves are summed unsigned and the absolute
    // difference taken, so no signed arithmetic is needed.
    assign w_xp = 12'(w_p2) + {3'b000, w_p4, 1'b0} + 12'(w_p7);
    assign w_xn = 12'(w_p0) + {3'b000, w_p3, 1'b0} + 12'(w_p5);
    assign w_yp = 12'(w_p0) + {3'b000, w_p1, 1'b0} + 12'(w_p2);
    assign w_yn = 12'(w_p5) + {3'b000, w_p6, 1'b0} + 12'(w_p7);

    assign w_ax  = (w_xp >= w_xn) ? (w_xp - w_xn) : (w_xn - w_xp);
    assign w_ay  = (w_yp >= w_yn) ? (w_yp - w_yn) : (w_yn - w_yp);
    assign w_sum = w_ax + w_ay;

    assign o_mag = (w_sum > 12'(SAT_MAX)) ? SAT_MAX : w_sum[7:0];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: custom-instruction controller streaming 4 pixels per
// call through one shared Sobel kernel, returning 4 packed edge bytes.
// Ports:
//   clock, reset (sync, active high)
//   start, ciN    : CI strobe and number; answered when ciN == customId
//   valueA        : pixels (byte 3 = leftmost) or config data
//   valueB        : [1:0] op code (CONFIG, PUSH, STATUS, CLEAR)
//   done, result  : one-cycle completion pulse; result is 0 when done is 0
// Optional build macro SOBEL_THRESHOLD_EN: binarise each lane against a
// configurable threshold instead of returning the magnitude.
//
// state | meaning
// IDLE  | waiting for a CI start; CONFIG/STATUS/CLEAR complete from here
// LOAD  | reading word k of both line buffers
// C0-C3 | kernel evaluates lane 0..3, result byte registered
// DONE  | done pulse; line buffers, carries and counters updated
module sobel_stream_ctrl
    import sobel_stream_pkg::*;
#(
    parameter logic [7:0] customId  = 8'h00,
    parameter int         MAX_WIDTH = 640
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic        done,
    output logic [31:0] result
);

    localparam int          DEPTH     = MAX_WIDTH / 4;
    localparam int          KW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] WIDTH_MAX = 11'(MAX_WIDTH);

    state_t      r_state;
    logic [KW-1:0] r_k;
    logic [15:0] r_row;
    logic [1:0]  r_vld;
    logic [10:0] r_width;
    logic [15:0] r_cy0, r_cy1, r_cy2;
    logic [31:0] r_pix;
    logic [7:0]  r_lane0, r_lane1, r_lane2;
    logic        r_done;
    logic [31:0] r_result;
    logic [31:0] r_rd1, r_rd2;
    logic [31:0] r_lb1 [DEPTH];
    logic [31:0] r_lb2 [DEPTH];
`ifdef SOBEL_THRESHOLD_EN
    logic [7:0]  r_thr;
`endif

    logic        w_accept, w_last, w_border, w_wr;
    logic [8:0]  w_kmax;
    logic [1:0]  w_lane;
    logic [4:0]  w_sh;
    logic [23:0] w_top, w_mid, w_bot;
    logic [63:0] w_nbr;
    logic [7:0]  w_mag, w_px, w_byte;
    logic [31:0] w_status;
    logic        w_unused_ok;

    assign w_accept = start && (ciN == customId) && (r_state == IDLE);
    assign w_kmax   = r_width[10:2] - 9'd1;
    // >= rather than == keeps the column counter bounded if width ever shrinks.
    assign w_last   = 16'(r_k) >= 16'(w_kmax);
    assign w_wr     = (r_state == DONE) && !reset;

    always_comb begin
        w_lane = 2'd0;
        case (r_state)
            C1:      w_lane = 2'd1;
            C2:      w_lane = 2'd2;
            C3:      w_lane = 2'd3;
            default: w_lane = 2'd0;
        endcase
    end

    // Each row is 6 bytes wide: two carried columns then the 4 of word k.
    // Lane n uses bytes n..n+2 counted from the left.
    assign w_sh  = {2'd3 - w_lane, 3'b000};
    assign w_top = 24'({r_cy2, r_rd2} >> w_sh);
    assign w_mid = 24'({r_cy1, r_rd1} >> w_sh);
    assign w_bot = 24'({r_cy0, r_pix} >> w_sh);

    assign w_nbr = {w_bot[7:0], w_bot[15:8], w_bot[23:16],
                    w_mid[7:0], w_mid[23:16],
                    w_top[7:0], w_top[15:8], w_top[23:16]};

    sobel_kernel u_kernel (
        .i_nbr (w_nbr),
        .o_mag (w_mag)
    );

    // Lanes 0/1 of word 0 are centred on columns -1 and 0.
    assign w_border = (r_vld != 2'd2) || ((r_k == '0) && !w_lane[1]);

`ifdef SOBEL_THRESHOLD_EN
    assign w_px     = (w_mag >= r_thr) ? 8'hFF : 8'h00;
    assign w_status = {r_thr[7:3], r_width, r_row};
`else
    assign w_px     = w_mag;
    assign w_status = {5'b00000, r_width, r_row};
`endif
    assign w_byte = w_border ? 8'h00 : w_px;

    assign w_unused_ok = ^{valueB[31:2], w_mid[15:8]};

    always_ff @(posedge clock) begin
        if (r_state == LOAD) begin
            r_rd1 <= r_lb1[r_k];
            r_rd2 <= r_lb2[r_k];
        end
        if (w_wr) begin
            r_lb1[r_k] <= r_pix;
            r_lb2[r_k] <= r_rd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_row    <= '0;
            r_vld    <= '0;
            r_width  <= WIDTH_MAX;
            r_cy0    <= '0;
            r_cy1    <= '0;
            r_cy2    <= '0;
            r_pix    <= '0;
            r_lane0  <= '0;
            r_lane1  <= '0;
            r_lane2  <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
`ifdef SOBEL_THRESHOLD_EN
            r_thr    <= 8'd128;
`endif
        end else begin
            r_done   <= 1'b0;
            r_result <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (valueB[1:0])
                            OP_CONFIG: begin
                                if (width_ok(valueA[10:0], WIDTH_MAX))
                                    r_width <= valueA[10:0];
`ifdef SOBEL_THRESHOLD_EN
                                r_thr  <= valueA[23:16];
`endif
                                r_done <= 1'b1;
                            end
                            OP_PUSH: begin
                                r_pix   <= valueA;
                                r_state <= LOAD;
                            end
                            OP_STATUS: begin
                                r_done   <= 1'b1;
                                r_result <= w_status;
                            end
                            default: begin
                                r_k    <= '0;
                                r_row  <= '0;
                                r_vld  <= '0;
                                r_cy0  <= '0;
                                r_cy1  <= '0;
                                r_cy2  <= '0;
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                LOAD: r_state <= C0;
                C0: begin
                    r_lane0 <= w_byte;
                    r_state <= C1;
                end
                C1: begin
                    r_lane1 <= w_byte;
                    r_state <= C2;
                end
                C2: begin
                    r_lane2 <= w_byte;
                    r_state <= C3;
                end
                C3: begin
                    r_done   <= 1'b1;
                    r_result <= {r_lane0, r_lane1, r_lane2, w_byte};
                    r_state  <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                    if (w_last) begin
                        r_k   <= '0;
                        r_row <= r_row + 16'd1;
                        if (r_vld != 2'd2)
                            r_vld <= r_vld + 2'd1;
                        r_cy0 <= '0;
                        r_cy1 <= '0;
                        r_cy2 <= '0;
                    end else begin
                        r_k   <= r_k + 1'b1;
                        r_cy0 <= r_pix[15:0];
                        r_cy1 <= r_rd1[15:0];
                        r_cy2 <= r_rd2[15:0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
module tb_sobel_stream_ctrl;

    localparam int         MAXW = 640;
    localparam logic [7:0] CID  = 8'h00;
    localparam logic [1:0] OPC = 2'd0, OPP = 2'd1, OPS = 2'd2, OPL = 2'd3;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] valueA = '0;
    logic [31:0] valueB = '0;
    logic [7:0]  ciN    = '0;
    logic        done;
    logic [31:0] result;

    sobel_stream_ctrl #(.customId(CID), .MAX_WIDTH(MAXW)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .valueA (valueA),
        .valueB (valueB),
        .ciN    (ciN),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_tot  = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h at t=%0t", name, act, req, $time);
    endtask

    // Reference model: whole image rows kept as byte arrays by column.
    int         m_width, m_k, m_row, m_vld;
    logic [7:0] m_thr;
    logic [7:0] m_r2 [MAXW];
    logic [7:0] m_r1 [MAXW];
    logic [7:0] m_r0 [MAXW];

    task automatic m_reset();
        m_width = MAXW; m_k = 0; m_row = 0; m_vld = 0; m_thr = 8'd128;
    endtask

    task automatic m_clear();
        m_k = 0; m_row = 0; m_vld = 0;
    endtask

    task automatic m_config(input logic [31:0] a);
        int w;
        w = int'(a[10:0]);
        if ((w % 4 == 0) && (w >= 8) && (w <= MAXW)) m_width = w;
        m_thr = a[23:16];
    endtask

    function automatic logic [31:0] m_status();
`ifdef SOBEL_THRESHOLD_EN
        return {m_thr[7:3], 11'(m_width), 16'(m_row)};
`else
        return {5'b00000, 11'(m_width), 16'(m_row)};
`endif
    endfunction

    // r: 0 = two rows above the newest, 1 = previous row, 2 = row being pushed
    function automatic int mpx(input int r, input int c);
        case (r)
            0:       return int'(m_r2[c]);
            1:       return int'(m_r1[c]);
            default: return int'(m_r0[c]);
        endcase
    endfunction

    function automatic logic [7:0] m_lane(input int c);
        int gx, gy, mag;
        if (m_vld < 2 || c < 1) return 8'h00;
        gx = (mpx(0, c+1) + 2*mpx(1, c+1) + mpx(2, c+1)) - (mpx(0, c-1) + 2*mpx(1, c-1) + mpx(2, c-1));
        gy = (mpx(0, c-1) + 2*mpx(0, c) + mpx(0, c+1)) - (mpx(2, c-1) + 2*mpx(2, c) + mpx(2, c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= int'(m_thr)) ? 8'hFF : 8'h00;
`else
        return 8'(mag);
`endif
    endfunction

    task automatic m_push(input logic [31:0] a, output logic [31:0] res);
        for (int n = 0; n < 4; n++) m_r0[4*m_k + n] = a[31-8*n -: 8];
        res = '0;
        for (int n = 0; n < 4; n++) res = {res[23:0], m_lane(4*m_k - 1 + n)};
        if (m_k == m_width/4 - 1) begin
            for (int c = 0; c < MAXW; c++) begin
                m_r2[c] = m_r1[c];
                m_r1[c] = m_r0[c];
            end
            m_k = 0;
            m_row = (m_row + 1) & 16'hFFFF;
            if (m_vld < 2) m_vld++;
        end else begin
            m_k++;
        end
    endtask

    // Monitor: done must rise exactly when the oldest expectation is due.
    always @(negedge clock) begin
        exp_t e;
        bit   due;
        if (mon_on) begin
            due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("done", {31'd0, done}, {31'd0, due});
            if (due) begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
            end else begin
                chk("result_idle", result, 32'd0);
            end
        end
    end

    task automatic ci_op(input logic [1:0] op, input logic [31:0] a);
        exp_t e;
        @(negedge clock);
        start  = 1'b1;
        valueA = a;
        valueB = ($urandom & 32'hFFFF_FFFC) | 32'(op);
        ciN    = CID;
        e.cyc  = cyc + 1;
        case (op)
            OPC: begin m_config(a); e.res = '0; end
            OPS: e.res = m_status();
            default: begin m_clear(); e.res = '0; end
        endcase
        exp_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic ci_foreign();
        @(negedge clock);
        start  = 1'b1;
        valueA = $urandom;
        valueB = $urandom;
        ciN    = CID ^ 8'($urandom_range(1, 255));
        @(negedge clock);
        start = 1'b0;
        ciN   = CID;
    endtask

    // intr_at: extra start injected j cycles after the push (0 = none)
    // abort_at: reset pulsed j cycles after the push (0 = none)
    task automatic push_word(input logic [31:0] a, input int intr_at, input int abort_at);
        exp_t        e;
        int          t0, last;
        logic [31:0] r;
        @(negedge clock);
        start  = 1'b1;
        valueA = a;
        valueB = ($urandom & 32'hFFFF_FFFC) | 32'(OPP);
        ciN    = CID;
        t0     = cyc;
        if (abort_at == 0) begin
            m_push(a, r);
            e.res = r;
            e.cyc = t0 + 6;
            exp_q.push_back(e);
        end
        last = 6;
        if (intr_at > 0 && intr_at + 1 > last) last = intr_at + 1;
        for (int j = 1; j <= last; j++) begin
            @(negedge clock);
            if (j == 1) start = 1'b0;
            if (j == intr_at) begin
                start  = 1'b1;
                valueA = $urandom;
                valueB = $urandom;
                ciN    = CID;
            end
            if (intr_at > 0 && j == intr_at + 1) start = 1'b0;
            if (j == abort_at) reset = 1'b1;
            if (abort_at > 0 && j == abort_at + 1) reset = 1'b0;
        end
        if (abort_at > 0) m_reset();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       w[8*i +: 8] = 8'($urandom);
                1:       w[8*i +: 8] = 8'h00;
                2:       w[8*i +: 8] = 8'hFF;
                default: w[8*i +: 8] = 8'($urandom_range(0, 40));
            endcase
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clock);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);

        ci_op(OPS, 32'd0);
        ci_op(OPC, 32'd16);
        ci_op(OPS, 32'd0);
        ci_op(OPC, 32'd18);
        ci_op(OPS, 32'd0);
        ci_op(OPC, 32'd4);
        ci_op(OPC, 32'd644);
        ci_op(OPS, 32'd0);
        ci_op(OPC, 32'd640);
        ci_op(OPS, 32'd0);

        ci_op(OPC, {8'd0, 8'd200, 16'd8});
        ci_op(OPL, 32'd0);
        repeat (6) push_word(32'd0, 0, 0);
        ci_op(OPS, 32'd0);

        ci_op(OPL, 32'd0);
        repeat (4) push_word(32'd0, 0, 0);
        push_word(32'h0000_004B, 0, 0);
        push_word(32'hFFFF_FFFF, 0, 0);
        push_word(32'h00FF_0000, 0, 0);
        push_word(32'h0000_0000, 0, 0);

        push_word(rand_word(), 4, 0);
        ci_foreign();
        push_word(rand_word(), 0, 0);
        push_word(rand_word(), 0, 3);
        ci_op(OPS, 32'd0);

        for (int t = 0; t < 6; t++) begin
            int w;
            int rows;
            w = 4 * int'($urandom_range(2, 8));
            ci_op(OPC, {8'($urandom), 8'($urandom), 5'($urandom), 11'(w)});
            ci_op(OPL, 32'd0);
            rows = int'($urandom_range(3, 4));
            for (int i = 0; i < rows * (w / 4); i++) begin
                case ($urandom_range(0, 9))
                    0:       ci_op(OPS, 32'd0);
                    1:       ci_foreign();
                    default: ;
                endcase
                push_word(rand_word(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0, 0);
            end
            ci_op(OPS, 32'd0);
        end

        repeat (10) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
